regfile_commit_writer: RTL and testbench
========================================

Name: regfile_commit_writer

Overview:
- In-order writer that drains retired results from the reorder buffer into the architectural register file's single write port (WriteRegister/WriteData/RegWrite).
- Holds a small FIFO of retired-but-not-yet-written results and applies backpressure to the ROB when the FIFO is full.
- Provides a youngest-match bypass lookup, so commit-side readers see values still in flight to the register file.
- X31 is the hardwired zero register; retirements targeting it are accepted and discarded.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- DATA_W, 64, result data width.
- ADDR_W, 5, architectural register index width.
- ZERO_REG, 31, register index that is never written.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- commitValid_i  input  1  ROB presents a retired result this cycle.
- commitAddr_i  input  ADDR_W  destination architectural register.
- commitData_i  input  DATA_W  result value.
- commitReady_o  output  1  writer can accept a result this cycle.
- wrStall_i  input  1  register-file write port unavailable; hold off popping.
- RegWrite_o  output  1  register-file write enable (registered).
- WriteRegister_o  output  ADDR_W  register-file write address (registered).
- WriteData_o  output  DATA_W  register-file write data (registered).
- bypassAddr_i  input  ADDR_W  lookup address.
- bypassHit_o  output  1  a pending write to bypassAddr_i exists.
- bypassData_o  output  DATA_W  value of the youngest pending write to bypassAddr_i.
- count_o  output  $clog2(DEPTH+1)  FIFO occupancy.
- empty_o  output  1  FIFO empty and no write in the output stage.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - head, tail and count clear to 0.
  - RegWrite_o=0, WriteRegister_o=0, WriteData_o=0.
  - commitReady_o=1, bypassHit_o=0, bypassData_o=0, empty_o=1.
  - Reset asserted mid-operation discards all queued and in-flight writes; nothing reaches the register file after reset_n falls.
- Accept condition:
  - commitReady_o = (count < DEPTH). It depends only on registered state, never on a same-cycle pop.
  - A handshake occurs on a rising edge where commitValid_i && commitReady_o.
  - If commitAddr_i == ZERO_REG, the result is accepted (ROB advances) but not enqueued; count is unchanged.
  - Otherwise {addr, data} is written at tail, tail increments modulo DEPTH, and count increments.
- Pop / write stage:
  - On each rising edge, if count>0 and !wrStall_i: head entry loads into WriteRegister_o/WriteData_o, RegWrite_o=1, head increments modulo DEPTH, count decrements.
  - Otherwise RegWrite_o=0 next cycle. WriteRegister_o and WriteData_o hold their last values.
  - wrStall_i only blocks pops; accepts continue until full.
- Latency: a result accepted at edge N is popped at edge N+1 at the earliest. RegWrite_o is high during cycle N+1, and the register file captures it at edge N+2.
- Simultaneous push and pop in one edge: count unchanged, both pointers advance.
- Full (count=DEPTH): commitReady_o=0 even if a pop occurs on the same edge.
- Empty: a result cannot be pushed and popped on the same edge. A push into an empty FIFO pops on the following edge.
- Ordering: register-file writes occur strictly in acceptance order. Two retirements to the same register both write, older first.
- Bypass (combinational from registered state only; current commit inputs excluded):
  - Searches valid FIFO entries from tail-1 back to head, then the output stage when RegWrite_o=1.
  - The first address match gives bypassHit_o=1 and bypassData_o=that data.
  - No match gives bypassHit_o=0, bypassData_o=0.
  - bypassAddr_i == ZERO_REG always gives hit=0, data=0.
- empty_o = (count==0) && !RegWrite_o.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full versus empty is distinguished by count.

Test Plan:
- Single write: reset, accept {addr=5, data=0xA5} at edge 1 -> RegWrite_o=1, WriteRegister_o=5, WriteData_o=0xA5 in cycle after edge 2; RegWrite_o=0 after edge 3; empty_o=1 after edge 3.
- Zero register drop: commit {31, 0xA0} with ready=1 -> accepted, count_o stays 0, RegWrite_o never asserts; bypassAddr_i=31 -> hit=0, data=0.
- Fill under stall: wrStall_i=1, commit regs 1..5 data 0x10..0x50 back-to-back -> regs 1-4 accepted, count_o=4, commitReady_o=0 on 5th; release stall -> writes 1,2,3,4 on consecutive cycles, then 5 is accepted and written; no loss or reorder.
- Bypass youngest-wins: wrStall_i=1, enqueue {7,0x1},{3,0x2},{7,0x3}; bypassAddr_i=7 -> hit=1, data=0x3; after the two pops covering {7,0x1} and {3,0x2} (entry {7,0x3} still queued) -> data=0x3; after all drained and RegWrite_o=0 -> hit=0.
- Wrap and simultaneous push/pop: stream 12 results to regs 0..11 with wrStall_i toggling every 3 cycles -> pointers wrap multiple times, count never exceeds 4, written sequence equals input sequence exactly.
- Async reset mid-flight: 3 entries queued and RegWrite_o=1, drive reset_n=0 between edges -> RegWrite_o=0, count_o=0, commitReady_o=1 immediately; after reset_n=1, no stale write appears.

Source files
------------

// File: rtl/regfile_commit_writer.sv
// In-order commit writer: buffers retired ROB results in a small FIFO and drains them,
// one per cycle, into the register file write port, with a youngest-match bypass lookup.
module regfile_commit_writer #(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       commitValid_i,
    input  logic [ADDR_W-1:0]          commitAddr_i,
    input  logic [DATA_W-1:0]          commitData_i,
    output logic                       commitReady_o,
    input  logic                       wrStall_i,
    output logic                       RegWrite_o,
    output logic [ADDR_W-1:0]          WriteRegister_o,
    output logic [DATA_W-1:0]          WriteData_o,
    input  logic [ADDR_W-1:0]          bypassAddr_i,
    output logic                       bypassHit_o,
    output logic [DATA_W-1:0]          bypassData_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              commit_ready;
    logic              push;
    logic              pop;
    logic              bypass_hit;
    logic [DATA_W-1:0] bypass_data;
    logic [PTR_W-1:0]  scan_idx;

    // Ready and pop both look only at registered count, so an empty FIFO can never
    // push and pop the same entry on one edge, and a full FIFO stays not-ready.
    assign commit_ready = (count_q < CNT_W'(DEPTH));
    assign push         = commitValid_i && commit_ready && (commitAddr_i != ZERO_ADDR);
    assign pop          = (count_q != '0) && !wrStall_i;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        reg_write_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d      = head_q + 1'b1;
            reg_write_d = 1'b1;
            wr_addr_d   = mem_addr_q[head_q];
            wr_data_d   = mem_data_q[head_q];
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            reg_write_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            reg_write_q <= reg_write_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // NOTE: storage is not reset; an entry is only ever read while count says it is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[tail_q] <= commitAddr_i;
            mem_data_q[tail_q] <= commitData_i;
        end
    end

    // Scan oldest to youngest so a later match overrides an earlier one; the output
    // stage is older than anything still queued.
    always_comb begin
        bypass_hit  = 1'b0;
        bypass_data = '0;
        scan_idx    = head_q;

        if (reg_write_q && (wr_addr_q == bypassAddr_i)) begin
            bypass_hit  = 1'b1;
            bypass_data = wr_data_q;
        end

        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (mem_addr_q[scan_idx] == bypassAddr_i)) begin
                bypass_hit  = 1'b1;
                bypass_data = mem_data_q[scan_idx];
            end
        end

        if (bypassAddr_i == ZERO_ADDR) begin
            bypass_hit  = 1'b0;
            bypass_data = '0;
        end
    end

    assign commitReady_o   = commit_ready;
    assign RegWrite_o      = reg_write_q;
    assign WriteRegister_o = wr_addr_q;
    assign WriteData_o     = wr_data_q;
    assign bypassHit_o     = bypass_hit;
    assign bypassData_o    = bypass_data;
    assign count_o         = count_q;
    assign empty_o         = (count_q == '0) && !reg_write_q;

endmodule

// File: tb/tb_regfile_commit_writer.sv
// Self-checking bench for regfile_commit_writer: a scoreboard queue holds accepted
// results in order and is popped whenever the write port fires.
module tb_regfile_commit_writer;

    logic        clk;
    logic        reset_n;
    logic        commitValid_i;
    logic [4:0]  commitAddr_i;
    logic [63:0] commitData_i;
    logic        commitReady_o;
    logic        wrStall_i;
    logic        RegWrite_o;
    logic [4:0]  WriteRegister_o;
    logic [63:0] WriteData_o;
    logic [4:0]  bypassAddr_i;
    logic        bypassHit_o;
    logic [63:0] bypassData_o;
    logic [2:0]  count_o;
    logic        empty_o;

    regfile_commit_writer #(.DEPTH(4), .DATA_W(64), .ADDR_W(5), .ZERO_REG(31)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .commitValid_i   (commitValid_i),
        .commitAddr_i    (commitAddr_i),
        .commitData_i    (commitData_i),
        .commitReady_o   (commitReady_o),
        .wrStall_i       (wrStall_i),
        .RegWrite_o      (RegWrite_o),
        .WriteRegister_o (WriteRegister_o),
        .WriteData_o     (WriteData_o),
        .bypassAddr_i    (bypassAddr_i),
        .bypassHit_o     (bypassHit_o),
        .bypassData_o    (bypassData_o),
        .count_o         (count_o),
        .empty_o         (empty_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int mdl_cnt  = 0;
    logic [68:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    // One clock cycle: drive at the falling edge, predict, then check after the next falling edge.
    task automatic step(input logic v, input logic [4:0] a, input logic [63:0] d,
                        input logic st, output logic acc);
        logic        exp_rdy;
        logic        do_pop;
        logic [68:0] e;
        exp_rdy       = (mdl_cnt < 4);
        commitValid_i = v;
        commitAddr_i  = a;
        commitData_i  = d;
        wrStall_i     = st;
        #1;
        n_checks++;
        if (commitReady_o !== exp_rdy)
            $display("FAIL ready: got %b expected %b", commitReady_o, exp_rdy);
        else n_pass++;
        acc    = v && exp_rdy;
        do_pop = (mdl_cnt > 0) && !st;
        if (acc && a != 5'd31) begin
            exp_q.push_back({a, d});
            mdl_cnt++;
        end
        if (do_pop) mdl_cnt--;
        @(posedge clk);
        @(negedge clk);
        commitValid_i = 1'b0;
        n_checks++;
        if (RegWrite_o !== do_pop)
            $display("FAIL regwrite: got %b expected %b", RegWrite_o, do_pop);
        else n_pass++;
        if (do_pop && RegWrite_o === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_order: got write to %0d with nothing expected", WriteRegister_o);
            end else begin
                e = exp_q.pop_front();
                if ({WriteRegister_o, WriteData_o} !== e)
                    $display("FAIL write_order: got reg %0d data %h expected reg %0d data %h",
                             WriteRegister_o, WriteData_o, e[68:64], e[63:0]);
                else n_pass++;
            end
        end
        n_checks++;
        if (count_o !== 3'(mdl_cnt))
            $display("FAIL count: got %0d expected %0d", count_o, mdl_cnt);
        else n_pass++;
        n_checks++;
        if (empty_o !== (mdl_cnt == 0 && !do_pop))
            $display("FAIL empty: got %b expected %b", empty_o, (mdl_cnt == 0 && !do_pop));
        else n_pass++;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 12 && (mdl_cnt > 0 || RegWrite_o); i++) step(1'b0, 5'd0, 64'd0, 1'b0, acc);
        n_checks++;
        if (exp_q.size() != 0 || RegWrite_o !== 1'b0)
            $display("FAIL drain: got %0d entries pending expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_checks++;
        if ({RegWrite_o, WriteRegister_o, WriteData_o, count_o, commitReady_o, bypassHit_o, bypassData_o, empty_o}
            !== {1'b0, 5'd0, 64'd0, 3'd0, 1'b1, 1'b0, 64'd0, 1'b1})
            $display("FAIL reset_state: got wr=%b reg=%0d cnt=%0d rdy=%b hit=%b empty=%b expected 0,0,0,1,0,1",
                     RegWrite_o, WriteRegister_o, count_o, commitReady_o, bypassHit_o, empty_o);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_write();
        logic acc;
        step(1'b1, 5'd5, 64'hA5, 1'b0, acc);
        step(1'b0, 5'd0, 64'd0, 1'b0, acc);
        step(1'b0, 5'd0, 64'd0, 1'b0, acc);
    endtask

    task automatic test_zero_reg();
        logic acc;
        step(1'b1, 5'd31, 64'hA0, 1'b0, acc);
        n_checks++;
        if (acc !== 1'b1) $display("FAIL zero_accept: got %b expected 1", acc);
        else n_pass++;
        step(1'b0, 5'd0, 64'd0, 1'b0, acc);
        bypassAddr_i = 5'd31;
        #1;
        n_checks++;
        if ({bypassHit_o, bypassData_o} !== {1'b0, 64'd0})
            $display("FAIL zero_bypass: got hit=%b data=%h expected 0/0", bypassHit_o, bypassData_o);
        else n_pass++;
    endtask

    task automatic test_fill_stall();
        logic acc;
        int   tries;
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 5'(i), 64'(i * 16), 1'b1, acc);
            n_checks++;
            if (acc !== (i <= 4)) $display("FAIL fill_accept%0d: got %b expected %b", i, acc, (i <= 4));
            else n_pass++;
        end
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 8) begin
            step(1'b1, 5'd5, 64'h50, 1'b0, acc);
            tries++;
        end
        n_checks++;
        if (tries != 2) $display("FAIL fill_retry: got accept after %0d cycles expected 2", tries);
        else n_pass++;
        drain();
    endtask

    task automatic test_bypass();
        logic acc;
        step(1'b1, 5'd7, 64'h1, 1'b1, acc);
        step(1'b1, 5'd3, 64'h2, 1'b1, acc);
        step(1'b1, 5'd7, 64'h3, 1'b1, acc);
        bypassAddr_i = 5'd7; #1;
        n_checks++;
        if ({bypassHit_o, bypassData_o} !== {1'b1, 64'h3})
            $display("FAIL bypass_youngest: got hit=%b data=%h expected 1/3", bypassHit_o, bypassData_o);
        else n_pass++;
        bypassAddr_i = 5'd9; #1;
        n_checks++;
        if ({bypassHit_o, bypassData_o} !== {1'b0, 64'h0})
            $display("FAIL bypass_miss: got hit=%b data=%h expected 0/0", bypassHit_o, bypassData_o);
        else n_pass++;
        step(1'b0, 5'd0, 64'd0, 1'b0, acc);
        bypassAddr_i = 5'd3; #1;
        n_checks++;
        if ({bypassHit_o, bypassData_o} !== {1'b1, 64'h2})
            $display("FAIL bypass_queued: got hit=%b data=%h expected 1/2", bypassHit_o, bypassData_o);
        else n_pass++;
        step(1'b0, 5'd0, 64'd0, 1'b0, acc);
        bypassAddr_i = 5'd7; #1;
        n_checks++;
        if ({bypassHit_o, bypassData_o} !== {1'b1, 64'h3})
            $display("FAIL bypass_after_pops: got hit=%b data=%h expected 1/3", bypassHit_o, bypassData_o);
        else n_pass++;
        bypassAddr_i = 5'd3; #1;
        n_checks++;
        if ({bypassHit_o, bypassData_o} !== {1'b1, 64'h2})
            $display("FAIL bypass_outstage: got hit=%b data=%h expected 1/2", bypassHit_o, bypassData_o);
        else n_pass++;
        bypassAddr_i = 5'd7;
        drain();
        #1;
        n_checks++;
        if ({bypassHit_o, bypassData_o} !== {1'b0, 64'h0})
            $display("FAIL bypass_drained: got hit=%b data=%h expected 0/0", bypassHit_o, bypassData_o);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic        acc;
        logic [63:0] data [12];
        int          k;
        for (int i = 0; i < 12; i++) data[i] = {$urandom, $urandom};
        k = 0;
        for (int cyc = 0; cyc < 80 && k < 12; cyc++) begin
            step(1'b1, 5'(k), data[k], 1'((cyc / 3) % 2), acc);
            if (acc) k++;
        end
        n_checks++;
        if (k != 12) $display("FAIL wrap_accepts: got %0d expected 12", k);
        else n_pass++;
        drain();
    endtask

    task automatic test_async_reset();
        logic acc;
        for (int i = 0; i < 4; i++) step(1'b1, 5'(20 + i), 64'(100 + i), 1'b1, acc);
        step(1'b0, 5'd0, 64'd0, 1'b0, acc);
        wrStall_i = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({RegWrite_o, count_o, commitReady_o, empty_o} !== {1'b0, 3'd0, 1'b1, 1'b1})
            $display("FAIL async_reset: got wr=%b cnt=%0d rdy=%b empty=%b expected 0,0,1,1",
                     RegWrite_o, count_o, commitReady_o, empty_o);
        else n_pass++;
        exp_q.delete();
        mdl_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 64'd0, 1'b0, acc);
    endtask

    initial begin
        commitValid_i = 1'b0;
        commitAddr_i  = '0;
        commitData_i  = '0;
        wrStall_i     = 1'b0;
        bypassAddr_i  = 5'd0;
        test_reset();
        test_single_write();
        test_zero_reg();
        test_fill_stall();
        test_bypass();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
